// File: rtl/switch_block_loader_if.sv
// switch_block_loader_if: load/handshake bundle between a word source and the block loader.
//   master: drives bits, mode_in, load_en, clear, blk_ready; reads key_out, data_out,
//           mode_out, blk_valid, state_led
//   slave : the loader side (directions reversed)
interface switch_block_loader_if #(
    parameter int WORD_W = 16,
    parameter int WORDS  = 8
);
    logic [WORD_W-1:0]        bits;
    logic                     mode_in;
    logic                     load_en;
    logic                     clear;
    logic                     blk_ready;
    logic [WORD_W*WORDS-1:0]  key_out;
    logic [WORD_W*WORDS-1:0]  data_out;
    logic                     mode_out;
    logic                     blk_valid;
    logic [4:0]               state_led;

    modport master (
        output bits, mode_in, load_en, clear, blk_ready,
        input  key_out, data_out, mode_out, blk_valid, state_led
    );

    modport slave (
        input  bits, mode_in, load_en, clear, blk_ready,
        output key_out, data_out, mode_out, blk_valid, state_led
    );
endinterface

// File: rtl/switch_block_loader.sv
// switch_block_loader: assembles eight switch words of key then eight of data into 128-bit
// blocks and offers them to a cipher core with a valid/ready handshake.
//   man_clk : clock (rising edge)
//   reset   : asynchronous active-low reset
//   bus     : switch_block_loader_if.slave (word input, control, assembled block, LEDs)
module switch_block_loader #(
    parameter int WORD_W = 16,
    parameter int WORDS  = 8
) (
    input logic                  man_clk,
    input logic                  reset,
    switch_block_loader_if.slave bus
);
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE = 2'b00, KEY = 2'b01, DATA = 2'b10, OFFER = 2'b11} state_t;

    state_t                  state;
    logic [IW-1:0]           word_idx;
    logic [WORD_W*WORDS-1:0] key;
    logic [WORD_W*WORDS-1:0] data;
    logic                    mode;
    logic                    valid;
    logic                    last;
    logic [IW-1:0]           next_idx;
    int                      slot;

    assign last     = word_idx == IW'(WORDS - 1);
    assign next_idx = last ? '0 : word_idx + 1'b1;
    // word 0 lands in the most significant slot
    assign slot     = (WORDS - 1 - int'(word_idx)) * WORD_W;

    always_ff @(posedge man_clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            word_idx <= '0;
            key      <= '0;
            data     <= '0;
            mode     <= 1'b0;
            valid    <= 1'b0;
        end else if (bus.clear) begin
            // key/data are left intact; the next load overwrites them
            state    <= IDLE;
            word_idx <= '0;
            valid    <= 1'b0;
        end else if (state == OFFER) begin
            if (bus.blk_ready) begin
                state <= IDLE;
                valid <= 1'b0;
            end
        end else if (bus.load_en) begin
            // word_idx is always 0 in IDLE, so the IDLE capture is key word 0
            if (state == IDLE)
                mode <= bus.mode_in;
            if (state == DATA)
                data[slot +: WORD_W] <= bus.bits;
            else
                key[slot +: WORD_W] <= bus.bits;
            word_idx <= next_idx;
            state    <= state == IDLE ? KEY : !last ? state : state == KEY ? DATA : OFFER;
            valid    <= state == DATA && last;
        end
    end

    assign bus.key_out   = key;
    assign bus.data_out  = data;
    assign bus.mode_out  = mode;
    assign bus.blk_valid = valid;
    assign bus.state_led = {state, word_idx};
endmodule

// File: tb/tb_switch_block_loader.sv
// tb_switch_block_loader: directed vector table plus hand sequences for handshake, mode latch,
// abort and asynchronous reset.
module tb_switch_block_loader;
    logic man_clk = 1'b0;
    logic reset   = 1'b1;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    always #5 man_clk = ~man_clk;

    switch_block_loader_if #(.WORD_W(16), .WORDS(8)) bus ();

    switch_block_loader #(.WORD_W(16), .WORDS(8)) dut (
        .man_clk(man_clk),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        logic        ld;
        logic [15:0] bits;
        logic        mode;
        logic        clr;
        logic        rdy;
        logic [4:0]  led;
        logic        valid;
    } vec_t;

    vec_t tv[20];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [15:0] b, input logic m,
                         input logic clr, input logic rdy);
        bus.load_en   = ld;
        bus.bits      = b;
        bus.mode_in   = m;
        bus.clear     = clr;
        bus.blk_ready = rdy;
    endtask

    task automatic step();
        @(posedge man_clk);
        #1;
    endtask

    task automatic load(input int n, input logic [15:0] base, input logic m);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 16'(i), m, 1'b0, 1'b0);
            step();
        end
    endtask

    // eight consecutive words starting at base, word 0 in the top slot
    function automatic logic [127:0] blk(input logic [15:0] base);
        logic [127:0] v;
        for (int i = 0; i < 8; i++)
            v[127-16*i -: 16] = base + 16'(i);
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_key"},   bus.key_out,   128'h0);
        chk({tag, "_data"},  bus.data_out,  128'h0);
        chk({tag, "_mode"},  bus.mode_out,  128'h0);
        chk({tag, "_valid"}, bus.blk_valid, 128'h0);
        chk({tag, "_led"},   bus.state_led, 128'h0);
    endtask

    initial begin
        // full load with pauses and a stray blk_ready in KEY, then OFFER ignoring inputs
        tv[0]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 5'b01001, 1'b0};
        tv[1]  = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 5'b01001, 1'b0};
        tv[2]  = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 5'b01010, 1'b0};
        tv[3]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 5'b01011, 1'b0};
        tv[4]  = '{1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 5'b01011, 1'b0};
        tv[5]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 5'b01100, 1'b0};
        tv[6]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 5'b01101, 1'b0};
        tv[7]  = '{1'b1, 16'h0006, 1'b0, 1'b0, 1'b0, 5'b01110, 1'b0};
        tv[8]  = '{1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 5'b01111, 1'b0};
        tv[9]  = '{1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 5'b10000, 1'b0};
        tv[10] = '{1'b1, 16'h0009, 1'b0, 1'b0, 1'b0, 5'b10001, 1'b0};
        tv[11] = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 5'b10010, 1'b0};
        tv[12] = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 5'b10011, 1'b0};
        tv[13] = '{1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 5'b10100, 1'b0};
        tv[14] = '{1'b1, 16'h000D, 1'b0, 1'b0, 1'b0, 5'b10101, 1'b0};
        tv[15] = '{1'b1, 16'h000E, 1'b0, 1'b0, 1'b0, 5'b10110, 1'b0};
        tv[16] = '{1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 5'b10111, 1'b0};
        tv[17] = '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 5'b11000, 1'b1};
        tv[18] = '{1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 5'b11000, 1'b1};
        tv[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0};

        drive(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 chk_zero("reset");
        step();
        chk("reset_hold_led", bus.state_led, 128'h0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk("release_led", bus.state_led, 128'h0);
        chk("release_key", bus.key_out, 128'h0);

        for (int i = 0; i < 20; i++) begin
            drive(tv[i].ld, tv[i].bits, tv[i].mode, tv[i].clr, tv[i].rdy);
            step();
            chk($sformatf("tv%0d_led", i),   bus.state_led, tv[i].led);
            chk($sformatf("tv%0d_valid", i), bus.blk_valid, tv[i].valid);
        end
        chk("tv_key",  bus.key_out,  128'h0001_0002_0003_0004_0005_0006_0007_0008);
        chk("tv_data", bus.data_out, 128'h0009_000A_000B_000C_000D_000E_000F_0010);
        chk("tv_mode", bus.mode_out, 128'h0);

        // mode latched at start, changed after word 3; exact 16-word latency
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 16'(i + 1), i <= 3 ? 1'b1 : 1'b0, 1'b0, 1'b0);
            step();
            if (i == 14) chk("latency_early_valid", bus.blk_valid, 128'h0);
        end
        chk("full_valid", bus.blk_valid, 128'h1);
        chk("full_led",   bus.state_led, 128'h18);
        chk("full_mode",  bus.mode_out,  128'h1);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
            step();
            chk($sformatf("hold%0d_valid", c), bus.blk_valid, 128'h1);
            chk($sformatf("hold%0d_key", c),   bus.key_out,   blk(16'h0001));
            chk($sformatf("hold%0d_data", c),  bus.data_out,  blk(16'h0009));
            chk($sformatf("hold%0d_mode", c),  bus.mode_out,  128'h1);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("ack_led",   bus.state_led, 128'h0);
        chk("ack_valid", bus.blk_valid, 128'h0);
        chk("ack_mode",  bus.mode_out,  128'h1);

        // clear together with load_en at DATA word 5
        load(8, 16'h0100, 1'b0);
        load(5, 16'h0200, 1'b0);
        chk("pre_abort_led", bus.state_led, 128'h15);
        drive(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        step();
        chk("abort_led",   bus.state_led, 128'h0);
        chk("abort_valid", bus.blk_valid, 128'h0);
        chk("abort_key",   bus.key_out,   blk(16'h0100));
        chk("abort_data",  bus.data_out,  128'h0200_0201_0202_0203_0204_000E_000F_0010);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
            step();
            chk($sformatf("abort_idle%0d_valid", c), bus.blk_valid, 128'h0);
        end
        load(16, 16'h0A00, 1'b0);
        chk("reload_valid", bus.blk_valid, 128'h1);
        chk("reload_key",   bus.key_out,   blk(16'h0A00));
        chk("reload_data",  bus.data_out,  blk(16'h0A08));
        chk("reload_mode",  bus.mode_out,  128'h0);
        drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        step();
        chk("offer_clear_led",   bus.state_led, 128'h0);
        chk("offer_clear_valid", bus.blk_valid, 128'h0);

        // asynchronous reset during DATA word 3
        load(8, 16'h1000, 1'b1);
        load(3, 16'h2000, 1'b1);
        chk("pre_reset_led", bus.state_led, 128'h13);
        #2 reset = 1'b0;
        #1 chk_zero("midload_reset");
        drive(1'b1, 16'h7777, 1'b1, 1'b0, 1'b0);
        step();
        chk("midload_hold_led", bus.state_led, 128'h0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk("midload_release_led", bus.state_led, 128'h0);
        drive(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0);
        step();
        chk("restart_led",  bus.state_led, 128'h9);
        chk("restart_mode", bus.mode_out,  128'h1);
        chk("restart_key",  bus.key_out,   128'h5555_0000_0000_0000_0000_0000_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
